mem_responder: RTL and testbench
================================

# mem_responder

Fixed-latency main-memory model sitting at the far end of the cache fill interface. It accepts single-cycle read pulses (line fills) and write pulses (line writebacks) from a cache, queues them in order and serves them one at a time. After a fixed latency it returns each read as a full line on the receive port that the cache snoops. Used as the memory side for the I-cache in simulation and as the template for the future memory arbiter.

## Interface
Parameters:
- LATENCY, 4, WAIT cycles per served request (≥1)
- QUEUE_DEPTH, 4, request FIFO entries (≥ n_threads; power of two)
- MEM_LINES, 256, backing-store lines (power of two)

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  synchronous, active-high reset
- req_ren  in  1  read request pulse; one request per cycle
- req_wen  in  1  writeback request pulse
- req_addr  in  pptr_t  request byte address
- req_wdata  in  cacheline_t  writeback line
- rec_en  out  1  one-cycle response-valid pulse
- rec_addr  out  pptr_t  line-aligned address of response (offset bits zero)
- rec_cacheline  out  cacheline_t  returned line (4 × word_t)
- q_full  out  1  FIFO holds QUEUE_DEPTH entries
- busy  out  1  FSM not IDLE or FIFO non-empty
- overflow  out  1  sticky error: request dropped or illegal req_ren&req_wen

## Operation
- Enqueue: a cycle with req_ren|req_wen pushes {is_write, req_addr with offset[3:0] zeroed, req_wdata}.
  - Both req_ren and req_wen high: treated as write, read dropped, overflow←1.
- Full FIFO:
  - Push when count==QUEUE_DEPTH and no pop in the same cycle: request dropped, overflow←1.
  - Push and pop in the same cycle when full: push accepted.
- Store line index = addr[log2(MEM_LINES)+3:4]. Higher address bits alias (wrap).
- FSM states:
  - IDLE: if FIFO non-empty, pop head into op register, cnt←LATENCY-1, go to WAIT. Otherwise stay.
  - WAIT: if cnt≠0, cnt←cnt-1. If cnt==0:
    - read: rec_en←1, rec_addr←op addr, rec_cacheline←store[idx].
    - write: store[idx]←op wdata, no response.
    - Either way, go to IDLE.
- Ordering: strict FIFO. A read after a write to the same line returns the written data.
- rec_en defaults to 0 every cycle. rec_addr and rec_cacheline hold their last value between pulses.
- Reset (any cycle, including mid-WAIT):
  - FIFO emptied; in-flight op discarded with no response.
  - FSM←IDLE, all outputs 0, overflow cleared.
  - Store reinitialised: word w of line i = i*4+w (32-bit).

## Timing
- All outputs registered.
- Read presented in cycle t with the FSM idle and FIFO empty:
  - head visible t+1; popped end of t+1;
  - WAIT cycles t+2..t+LATENCY+1;
  - rec_en high in cycle t+LATENCY+2 only.
- Each request occupies the FSM for LATENCY+1 cycles (1 IDLE + LATENCY WAIT). Back-to-back queued reads produce rec_en pulses exactly LATENCY+1 cycles apart.
- q_full and busy reflect state after each edge.
- A push in the same cycle that makes count reach QUEUE_DEPTH raises q_full the next cycle.
- Write occupies the same slot timing. Store updated at the end of its last WAIT cycle.

## Test plan
- Reset, then read 0x0000_0040 in cycle 0 (LATENCY=4):
  - rec_en only in cycle 6;
  - rec_addr=0x40;
  - rec_cacheline words {0x10,0x11,0x12,0x13}.
- Read 0x0000_0048 (non-aligned):
  - rec_addr=0x40;
  - same line data as above.
- Write line 0x80 with {A,B,C,D}, next cycle read 0x84:
  - no rec_en for the write;
  - read returns {A,B,C,D} in cycle 11 relative to the write at 0.
- Four reads in cycles 0–3 (DEPTH=4):
  - q_full never drops a request;
  - rec_en in cycles 6, 11, 16, 21 with matching addresses in order.
- Fill the FIFO with the FSM in WAIT, push a 5th request:
  - request dropped, overflow=1 and sticky;
  - req_ren&req_wen together also sets overflow.
- Assert rst during WAIT of a pending read:
  - no rec_en ever for it;
  - busy=0, q_full=0, overflow=0 next cycle;
  - previously written line reads back as the init pattern.

Source files
------------

// File: rtl/mem_responder.sv
// Fixed-latency main-memory model for the cache fill interface: requests are queued
// in order, served one at a time, and each read returns a full line LATENCY+1 cycles after pop.
module mem_responder #(
    parameter int LATENCY     = 4,
    parameter int QUEUE_DEPTH = 4,
    parameter int MEM_LINES   = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_ren,
    input  logic         req_wen,
    input  logic [31:0]  req_addr,
    input  logic [127:0] req_wdata,
    output logic         rec_en,
    output logic [31:0]  rec_addr,
    output logic [127:0] rec_cacheline,
    output logic         q_full,
    output logic         busy,
    output logic         overflow
);

    localparam int IDX_W = $clog2(MEM_LINES);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t              state, state_next;
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count, count_next;
    logic                push, push_ok, pop, full;
    logic                resp_fire, store_fire;

    logic                fifo_wr   [QUEUE_DEPTH];
    logic [31:0]         fifo_addr [QUEUE_DEPTH];
    logic [127:0]        fifo_data [QUEUE_DEPTH];

    logic                op_wr;
    logic [31:0]         op_addr;
    logic [127:0]        op_wdata;
    logic [LAT_W-1:0]    cnt;
    logic [IDX_W-1:0]    op_idx;

    logic [127:0]        store [MEM_LINES];

    function automatic logic [127:0] init_line(input int line);
        logic [127:0] l;
        for (int w = 0; w < 4; w++) l[32*w +: 32] = 32'(line * 4 + w);
        return l;
    endfunction

    // A push into a full FIFO still lands if the head leaves in the same cycle.
    assign push    = req_ren | req_wen;
    assign full    = (count == FULL_CNT);
    assign push_ok = push && (!full || pop);
    assign op_idx  = op_addr[IDX_W+3:4];

    always_comb begin
        count_next = count;
        case ({push_ok, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
        end
    end

    // NOTE: FIFO payload arrays carry no reset; the count and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_wr[wr_ptr]   <= req_wen;
            fifo_addr[wr_ptr] <= req_addr & ~32'hF;
            fifo_data[wr_ptr] <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (count != '0) state_next = S_WAIT;
            S_WAIT:  if (cnt == '0)   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        pop        = 1'b0;
        resp_fire  = 1'b0;
        store_fire = 1'b0;
        case (state)
            S_IDLE: pop = (count != '0);
            S_WAIT: begin
                resp_fire  = (cnt == '0) && !op_wr;
                store_fire = (cnt == '0) &&  op_wr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_wr    <= 1'b0;
            op_addr  <= '0;
            op_wdata <= '0;
            cnt      <= '0;
        end else if (pop) begin
            op_wr    <= fifo_wr[rd_ptr];
            op_addr  <= fifo_addr[rd_ptr];
            op_wdata <= fifo_data[rd_ptr];
            cnt      <= LAT_W'(LATENCY - 1);
        end else if (state == S_WAIT && cnt != '0) begin
            cnt <= cnt - LAT_W'(1);
        end
    end

    // Reset restores the recognisable init pattern so fills after reset are predictable.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_LINES; i++) store[i] <= init_line(i);
        end else if (store_fire) begin
            store[op_idx] <= op_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rec_en        <= 1'b0;
            rec_addr      <= '0;
            rec_cacheline <= '0;
            q_full        <= 1'b0;
            busy          <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            rec_en <= resp_fire;
            if (resp_fire) begin
                rec_addr      <= op_addr;
                rec_cacheline <= store[op_idx];
            end
            q_full   <= (count_next == FULL_CNT);
            busy     <= (state_next != S_IDLE) || (count_next != '0);
            overflow <= overflow | (req_ren & req_wen) | (push & ~push_ok);
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (LATENCY=4, QUEUE_DEPTH=4, MEM_LINES=256):
// cycle numbers are counted from the cycle in which the first request of a scenario is driven.
module tb_mem_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_ren, req_wen;
    logic [31:0]  req_addr;
    logic [127:0] req_wdata;
    logic         rec_en;
    logic [31:0]  rec_addr;
    logic [127:0] rec_cacheline;
    logic         q_full, busy, overflow;

    typedef struct {
        int           cyc;
        logic [31:0]  addr;
        logic [127:0] data;
    } pulse_t;

    pulse_t pulses[$];
    int     cyc  = 0;
    int     base = 0;
    int     n_vec = 0;
    int     n_err = 0;

    localparam logic [127:0] LINE4 = 128'h00000013_00000012_00000011_00000010;
    localparam logic [127:0] WLINE = 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000;
    localparam logic [127:0] VLINE = 128'h0BADF00D_12345678_CAFEBABE_DEADBEEF;
    localparam logic [127:0] ZLINE = 128'h55555555_44444444_33333333_22222222;

    mem_responder dut (
        .clk          (clk),
        .rst          (rst),
        .req_ren      (req_ren),
        .req_wen      (req_wen),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rec_en       (rec_en),
        .rec_addr     (rec_addr),
        .rec_cacheline(rec_cacheline),
        .q_full       (q_full),
        .busy         (busy),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] pattern_line(input int line);
        logic [127:0] l;
        for (int w = 0; w < 4; w++) l[32*w +: 32] = 32'(line * 4 + w);
        return l;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (rec_en) pulses.push_back('{cyc, rec_addr, rec_cacheline});
    endtask

    task automatic run_to(input int rel);
        while (cyc < base + rel) step();
    endtask

    task automatic begin_scenario();
        pulses.delete();
        base = cyc;
    endtask

    task automatic chk_pulse(input string tag, input int i, input int exp_cyc,
                             input logic [31:0] a, input logic check_data, input logic [127:0] d);
        if (i < pulses.size()) begin
            check({tag, "_cyc"}, 128'(pulses[i].cyc - base), 128'(exp_cyc));
            check({tag, "_addr"}, 128'(pulses[i].addr), 128'(a));
            if (check_data) check({tag, "_line"}, pulses[i].data, d);
        end else begin
            check({tag, "_missing"}, 128'(pulses.size()), 128'(i + 1));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic drive(input logic ren, input logic wen, input logic [31:0] a, input logic [127:0] d);
        req_ren   = ren;
        req_wen   = wen;
        req_addr  = a;
        req_wdata = d;
    endtask

    initial begin
        drive(1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        check("rst_rec_en", 128'(rec_en), 128'(0));
        check("rst_rec_addr", 128'(rec_addr), 128'(0));
        check("rst_rec_line", rec_cacheline, 128'(0));
        check("rst_q_full", 128'(q_full), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_overflow", 128'(overflow), 128'(0));

        // Single aligned read: response in cycle 6 only.
        begin_scenario();
        drive(1'b1, 1'b0, 32'h0000_0040, '0);
        step();
        drive(1'b0, 1'b0, '0, '0);
        check("rd40_busy_c1", 128'(busy), 128'(1));
        run_to(7);
        check("rd40_hold_en", 128'(rec_en), 128'(0));
        check("rd40_hold_addr", 128'(rec_addr), 128'(32'h40));
        run_to(8);
        check("rd40_npulse", 128'(pulses.size()), 128'(1));
        chk_pulse("rd40", 0, 6, 32'h40, 1'b1, LINE4);
        check("rd40_busy_end", 128'(busy), 128'(0));

        // Non-aligned read returns the aligned address and the same line.
        begin_scenario();
        drive(1'b1, 1'b0, 32'h0000_0048, '0);
        step();
        drive(1'b0, 1'b0, '0, '0);
        run_to(8);
        check("rd48_npulse", 128'(pulses.size()), 128'(1));
        chk_pulse("rd48", 0, 6, 32'h40, 1'b1, LINE4);

        // High address bits alias onto the same store line.
        begin_scenario();
        drive(1'b1, 1'b0, 32'h1000_0044, '0);
        step();
        drive(1'b0, 1'b0, '0, '0);
        run_to(8);
        chk_pulse("alias", 0, 6, 32'h1000_0040, 1'b1, LINE4);

        // Write then read of the same line: single response carrying the written data.
        begin_scenario();
        drive(1'b0, 1'b1, 32'h0000_0080, WLINE);
        step();
        drive(1'b1, 1'b0, 32'h0000_0084, '0);
        step();
        drive(1'b0, 1'b0, '0, '0);
        run_to(13);
        check("wr_rd_npulse", 128'(pulses.size()), 128'(1));
        chk_pulse("wr_rd", 0, 11, 32'h80, 1'b1, WLINE);

        // Four back-to-back reads: responses LATENCY+1 cycles apart, in order.
        begin_scenario();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'h100 + 32'(16 * i), '0);
            step();
        end
        drive(1'b0, 1'b0, '0, '0);
        run_to(23);
        check("b2b_npulse", 128'(pulses.size()), 128'(4));
        for (int i = 0; i < 4; i++)
            chk_pulse($sformatf("b2b%0d", i), i, 6 + 5 * i, 32'h100 + 32'(16 * i), 1'b1,
                      pattern_line(16 + i));
        check("b2b_overflow", 128'(overflow), 128'(0));

        // Six pushes in cycles 0..5: FIFO full in cycle 5, sixth request dropped.
        begin_scenario();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 32'h200 + 32'(16 * i), '0);
            step();
            if (i == 4) check("ovf_q_full_c5", 128'(q_full), 128'(1));
            if (i == 4) check("ovf_clear_c5", 128'(overflow), 128'(0));
        end
        drive(1'b0, 1'b0, '0, '0);
        check("ovf_set_c6", 128'(overflow), 128'(1));
        run_to(33);
        check("ovf_npulse", 128'(pulses.size()), 128'(5));
        for (int i = 0; i < 5; i++)
            chk_pulse($sformatf("ovf%0d", i), i, 6 + 5 * i, 32'h200 + 32'(16 * i), 1'b0, '0);
        check("ovf_sticky", 128'(overflow), 128'(1));
        check("ovf_q_full_end", 128'(q_full), 128'(0));

        do_reset();
        check("ovf_after_rst", 128'(overflow), 128'(0));

        // Read and write together: treated as a write, overflow raised.
        begin_scenario();
        drive(1'b1, 1'b1, 32'h0000_0300, VLINE);
        step();
        check("rw_overflow", 128'(overflow), 128'(1));
        drive(1'b1, 1'b0, 32'h0000_0300, '0);
        step();
        drive(1'b0, 1'b0, '0, '0);
        run_to(13);
        check("rw_npulse", 128'(pulses.size()), 128'(1));
        chk_pulse("rw", 0, 11, 32'h300, 1'b1, VLINE);

        // Reset mid-WAIT: pending read vanishes and the store returns to its init pattern.
        do_reset();
        drive(1'b1, 1'b1, 32'h0000_0500, ZLINE);
        step();
        drive(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 8; i++) step();
        begin_scenario();
        drive(1'b1, 1'b0, 32'h0000_0500, '0);
        step();
        drive(1'b0, 1'b0, '0, '0);
        run_to(3);
        check("mid_busy_pre", 128'(busy), 128'(1));
        check("mid_ovf_pre", 128'(overflow), 128'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rec_en", 128'(rec_en), 128'(0));
        check("mid_busy", 128'(busy), 128'(0));
        check("mid_q_full", 128'(q_full), 128'(0));
        check("mid_overflow", 128'(overflow), 128'(0));
        check("mid_rec_addr", 128'(rec_addr), 128'(0));
        run_to(14);
        check("mid_npulse", 128'(pulses.size()), 128'(0));

        begin_scenario();
        drive(1'b1, 1'b0, 32'h0000_0500, '0);
        step();
        drive(1'b0, 1'b0, '0, '0);
        run_to(8);
        check("reinit_npulse", 128'(pulses.size()), 128'(1));
        chk_pulse("reinit", 0, 6, 32'h500, 1'b1, 128'h00000143_00000142_00000141_00000140);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
